// File: rtl/scan_bus_pkg.sv
// Shared types and frame-layout helpers for scan_bus_master.
// Frame layout, MSB first: op/status[1:0], ch[CH_W-1:0], addr[ADDR_W-1:0], data[DATA_W-1:0].
package scan_bus_pkg;

  typedef enum logic [1:0] {
    OP_NOP   = 2'b00,
    OP_READ  = 2'b01,
    OP_WRITE = 2'b10,
    OP_RSVD  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_OK      = 2'b00,
    ST_TIMEOUT = 2'b01,
    ST_BAD_CH  = 2'b10,
    ST_OVERRUN = 2'b11
  } status_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_e;

  function automatic int ch_w(input int n_ch);
    return (n_ch <= 1) ? 1 : $clog2(n_ch);
  endfunction

  function automatic int frame_w(input int n_ch, input int addr_w, input int data_w);
    return 2 + ch_w(n_ch) + addr_w + data_w;
  endfunction

  function automatic int addr_lsb(input int data_w);
    return data_w;
  endfunction

  function automatic int ch_lsb(input int addr_w, input int data_w);
    return addr_w + data_w;
  endfunction

  function automatic int op_lsb(input int n_ch, input int addr_w, input int data_w);
    return ch_w(n_ch) + addr_w + data_w;
  endfunction

  // Timeout counter width: wide enough for to_cyc, clamped to 8..32 bits.
  function automatic int to_w(input int to_cyc);
    int w;
    w = $clog2(to_cyc + 1);
    if (w < 8)  w = 8;
    if (w > 32) w = 32;
    return w;
  endfunction

endpackage

// File: rtl/scan_frame_reg.sv
// Scan frame register: serial shift toward MSB with parallel load; MSB drives the chain.
module scan_frame_reg #(
  parameter int W = 46
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         shift_en,
  input  logic         sin,
  input  logic         load_en,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] q,
  output logic         sout
);

  always_ff @(posedge clk) begin
    if (rst)           q <= '0;
    else if (load_en)  q <= load_val;
    else if (shift_en) q <= {q[W-2:0], sin};
  end

  assign sout = q[W-1];

endmodule

// File: rtl/scan_bus_master.sv
// Scan-driven bus master: scanned command frame -> one read/write on a selected channel -> response frame.
// Optional ready timeout enabled by defining SCAN_BUS_TIMEOUT_EN.
module scan_bus_master
  import scan_bus_pkg::*;
#(
  parameter int N_CH   = 2,
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32,
  parameter int TO_CYC = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   scan_shift,
  input  logic                   scan_data_in,
  output logic                   scan_data_out,
  input  logic                   scan_load,
  output logic                   scan_busy,
  output logic [N_CH-1:0]        mem_ren,
  output logic [N_CH-1:0]        mem_wen,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic [DATA_W-1:0]      mem_wdata,
  input  logic [N_CH*DATA_W-1:0] mem_rdata,
  input  logic [N_CH-1:0]        mem_ready
);

  localparam int CH_W     = ch_w(N_CH);
  localparam int FRAME_W  = frame_w(N_CH, ADDR_W, DATA_W);
  localparam int OP_LSB   = op_lsb(N_CH, ADDR_W, DATA_W);
  localparam int CH_LSB   = ch_lsb(ADDR_W, DATA_W);
  localparam int ADDR_LSB = addr_lsb(DATA_W);
  localparam logic [CH_W:0] N_CH_V = (CH_W+1)'(N_CH);

  state_e state, state_nxt;
  logic [FRAME_W-1:0] frame, resp_frame;

  op_e               op_q;
  logic [CH_W-1:0]   ch_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic              bad_q, ovr_q, to_q;

  op_e               f_op;
  logic [CH_W-1:0]   f_ch;
  logic              f_bad, f_go, load_ok;
  logic [N_CH-1:0]   ch_oh;
  logic              sel_ready, to_hit;
  logic [DATA_W-1:0] sel_rdata;
  status_e           status;

  assign scan_busy = (state != S_IDLE);
  assign load_ok   = scan_load && !scan_busy;

  assign f_op  = op_e'(frame[OP_LSB +: 2]);
  assign f_ch  = frame[CH_LSB +: CH_W];
  assign f_bad = ({1'b0, f_ch} >= N_CH_V);
  assign f_go  = ((f_op == OP_READ) || (f_op == OP_WRITE)) && !f_bad;

  // Channel select by one-hot decode, so non-power-of-two N_CH never indexes out of range.
  always_comb begin
    ch_oh     = '0;
    sel_rdata = '0;
    for (int c = 0; c < N_CH; c++) begin
      ch_oh[c] = (ch_q == CH_W'(c));
      if (ch_oh[c]) sel_rdata = mem_rdata[c*DATA_W +: DATA_W];
    end
  end
  assign sel_ready = |(mem_ready & ch_oh);

`ifdef SCAN_BUS_TIMEOUT_EN
  localparam int TO_W = to_w(TO_CYC);
  logic [TO_W-1:0] to_cnt;

  always_ff @(posedge clk) begin
    if (rst || state != S_WAIT) to_cnt <= '0;
    else                        to_cnt <= to_cnt + 1'b1;
  end
  assign to_hit = (state == S_WAIT) && !sel_ready && (to_cnt == TO_W'(TO_CYC - 1));
`else
  assign to_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (load_ok) state_nxt = f_go ? S_ISSUE : S_RESP;
      S_ISSUE: state_nxt = S_WAIT;
      S_WAIT:  if (sel_ready || to_hit) state_nxt = S_RESP;
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q      <= OP_NOP;
      ch_q      <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      bad_q     <= 1'b0;
      to_q      <= 1'b0;
      ovr_q     <= 1'b0;
      mem_ren   <= '0;
      mem_wen   <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      if (load_ok) begin
        op_q   <= f_op;
        ch_q   <= f_ch;
        addr_q <= frame[ADDR_LSB +: ADDR_W];
        data_q <= frame[DATA_W-1:0];
        bad_q  <= f_bad;
        to_q   <= 1'b0;
      end
      if (state == S_ISSUE) begin
        mem_addr  <= addr_q;
        mem_wdata <= data_q;
        mem_ren   <= (op_q == OP_READ)  ? ch_oh : '0;
        mem_wen   <= (op_q == OP_WRITE) ? ch_oh : '0;
      end
      if (state == S_WAIT) begin
        if (sel_ready) begin
          mem_ren <= '0;
          mem_wen <= '0;
          if (op_q == OP_READ) data_q <= sel_rdata;
        end else if (to_hit) begin
          mem_ren <= '0;
          mem_wen <= '0;
          data_q  <= '0;
          to_q    <= 1'b1;
        end
      end
      // A load arriving in the RESP cycle belongs to the next response.
      if (state == S_RESP)        ovr_q <= scan_load;
      else if (scan_load && scan_busy) ovr_q <= 1'b1;
    end
  end

  always_comb begin
    if (to_q)       status = ST_TIMEOUT;
    else if (bad_q) status = ST_BAD_CH;
    else if (ovr_q) status = ST_OVERRUN;
    else            status = ST_OK;
  end
  assign resp_frame = {status, ch_q, addr_q, data_q};

  scan_frame_reg #(.W(FRAME_W)) u_frame (
    .clk      (clk),
    .rst      (rst),
    .shift_en (scan_shift && !scan_busy && !scan_load),
    .sin      (scan_data_in),
    .load_en  (state == S_RESP),
    .load_val (resp_frame),
    .q        (frame),
    .sout     (scan_data_out)
  );

endmodule

// File: tb/tb_scan_bus_master.sv
// Bench for scan_bus_master: directed vector table, hand-written corner sequences, random commands vs a memory model.
module tb_scan_bus_master;
  localparam int AW = 11, DW = 32, FW = 46, TO = 16;

  logic clk = 1'b0;
  logic rst, scan_shift, scan_data_in, scan_load;
  logic sdo0, busy0, sdo1, busy1;
  logic [1:0] ren0, wen0, ready0;
  logic [0:0] ren1, wen1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic [2*DW-1:0] rdata0;

  scan_bus_master #(.N_CH(2), .ADDR_W(AW), .DATA_W(DW), .TO_CYC(TO)) u_dut (
    .clk(clk), .rst(rst), .scan_shift(scan_shift), .scan_data_in(scan_data_in),
    .scan_data_out(sdo0), .scan_load(scan_load), .scan_busy(busy0),
    .mem_ren(ren0), .mem_wen(wen0), .mem_addr(addr0), .mem_wdata(wdata0),
    .mem_rdata(rdata0), .mem_ready(ready0));

  // Single-channel build sharing the scan inputs, used for the BAD_CH case.
  scan_bus_master #(.N_CH(1), .ADDR_W(AW), .DATA_W(DW), .TO_CYC(TO)) u_bad (
    .clk(clk), .rst(rst), .scan_shift(scan_shift), .scan_data_in(scan_data_in),
    .scan_data_out(sdo1), .scan_load(scan_load), .scan_busy(busy1),
    .mem_ren(ren1), .mem_wen(wen1), .mem_addr(addr1), .mem_wdata(wdata1),
    .mem_rdata(32'h0), .mem_ready(1'b0));

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Memory environment: per-channel sparse spram, ready after rdy_delay strobe cycles.
  logic [DW-1:0] spram [int];
  logic [DW-1:0] model_mem [int];
  int  rdy_delay = 0;
  bit  hold_ready = 1'b0, noise = 1'b0;
  int  wcnt [2];

  initial begin
    ready0 = '0; rdata0 = '0; wcnt[0] = 0; wcnt[1] = 0;
    forever begin
      @(negedge clk);
      for (int c = 0; c < 2; c++) begin
        if ((ren0[c] || wen0[c]) && !hold_ready) begin
          if (wcnt[c] >= rdy_delay) begin
            int key;
            key = c*4096 + int'(addr0);
            ready0[c] = 1'b1;
            if (wen0[c]) spram[key] = wdata0;
            rdata0[c*DW +: DW] = spram.exists(key) ? spram[key] : '0;
          end else ready0[c] = 1'b0;
          wcnt[c]++;
        end else if (ren0[c] || wen0[c]) begin
          ready0[c] = 1'b0;
        end else begin
          wcnt[c] = 0;
          ready0[c] = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        end
      end
    end
  end

  // Strobe monitor, sampled shortly after each rising edge.
  int strb_cyc;
  logic [1:0] ren_or, wen_or;
  logic bad_strb;
  initial begin
    strb_cyc = 0; ren_or = '0; wen_or = '0; bad_strb = 1'b0;
    forever begin
      @(posedge clk); #2;
      if (|(ren0 | wen0)) strb_cyc++;
      ren_or   |= ren0;
      wen_or   |= wen0;
      bad_strb |= (|(ren1 | wen1));
    end
  end

  task automatic shift_in(input logic [FW-1:0] f);
    for (int i = FW-1; i >= 0; i--) begin
      scan_shift = 1'b1; scan_data_in = f[i];
      @(negedge clk);
    end
    scan_shift = 1'b0; scan_data_in = 1'b0;
  endtask

  task automatic pulse_load();
    strb_cyc = 0; ren_or = '0; wen_or = '0; bad_strb = 1'b0;
    scan_load = 1'b1;
    @(negedge clk);
    scan_load = 1'b0;
  endtask

  task automatic wait_idle(output int lat);
    lat = 0;
    while (busy0 && lat < 2000) begin
      @(negedge clk);
      lat++;
    end
    if (busy0) chk("busy_bound", 1, 0);
  endtask

  task automatic shift_out(output logic [FW-1:0] r0, output logic [FW-1:0] r1);
    for (int i = FW-1; i >= 0; i--) begin
      r0[i] = sdo0; r1[i] = sdo1;
      scan_shift = 1'b1;
      @(negedge clk);
    end
    scan_shift = 1'b0;
  endtask

  task automatic run_cmd(input logic [1:0] op, input logic ch, input logic [AW-1:0] a,
                         input logic [DW-1:0] wd, input int dly,
                         output logic [FW-1:0] r0, output int lat);
    logic [FW-1:0] r1;
    rdy_delay = dly;
    shift_in({op, ch, a, wd});
    pulse_load();
    wait_idle(lat);
    shift_out(r0, r1);
  endtask

  typedef struct {
    logic [1:0] op; logic ch; logic [AW-1:0] addr; logic [DW-1:0] wd; int dly;
    logic [DW-1:0] e_data; int e_lat; int e_strb; logic [1:0] e_ren; logic [1:0] e_wen;
  } vec_t;

  vec_t vecs [7];

  initial begin
    logic [FW-1:0] r0, r1;
    int lat;
    logic s_before;

    rst = 1'b1; scan_shift = 1'b0; scan_data_in = 1'b0; scan_load = 1'b0;
    vecs[0] = '{2'b10, 1'b0, 11'h015, 32'hDEADBEEF, 0, 32'hDEADBEEF, 3, 1, 2'b00, 2'b01};
    vecs[1] = '{2'b10, 1'b1, 11'h015, 32'h12345678, 2, 32'h12345678, 5, 3, 2'b00, 2'b10};
    vecs[2] = '{2'b01, 1'b1, 11'h015, 32'h00000000, 0, 32'h12345678, 3, 1, 2'b10, 2'b00};
    vecs[3] = '{2'b01, 1'b0, 11'h015, 32'hFFFF0000, 1, 32'hDEADBEEF, 4, 2, 2'b01, 2'b00};
    vecs[4] = '{2'b00, 1'b1, 11'h7FF, 32'hA5A5A5A5, 0, 32'hA5A5A5A5, 1, 0, 2'b00, 2'b00};
    vecs[5] = '{2'b11, 1'b0, 11'h123, 32'h0F0F0000, 0, 32'h0F0F0000, 1, 0, 2'b00, 2'b00};
    vecs[6] = '{2'b01, 1'b0, 11'h7FF, 32'h11111111, 3, 32'h00000000, 6, 4, 2'b01, 2'b00};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_sdo", sdo0, 0);   chk("rst_busy", busy0, 0);
    chk("rst_ren", ren0, 0);   chk("rst_wen", wen0, 0);
    chk("rst_addr", addr0, 0); chk("rst_wdata", wdata0, 0);
    chk("rst_sdo1", sdo1, 0);  chk("rst_busy1", busy1, 0);

    // BAD_CH on the single-channel build: one-cycle turnaround, no strobe.
    rdy_delay = 0;
    shift_in({2'b10, 1'b1, 11'h7F0, 32'h0BADC0DE});
    pulse_load();
    chk("bad_busy_hi", busy1, 1);
    @(negedge clk);
    chk("bad_busy_lo", busy1, 0);
    wait_idle(lat);
    shift_out(r0, r1);
    chk("bad_status", r1[45:44], 2'b10);
    chk("bad_ch", r1[43], 1);
    chk("bad_addr", r1[42:32], 11'h7F0);
    chk("bad_data", r1[31:0], 32'h0BADC0DE);
    chk("bad_nostrb", bad_strb, 0);
    chk("bad_ok_on_2ch", r0[45:44], 2'b00);

    foreach (vecs[i]) begin
      run_cmd(vecs[i].op, vecs[i].ch, vecs[i].addr, vecs[i].wd, vecs[i].dly, r0, lat);
      chk($sformatf("v%0d_status", i), r0[45:44], 2'b00);
      chk($sformatf("v%0d_ch", i), r0[43], vecs[i].ch);
      chk($sformatf("v%0d_addr", i), r0[42:32], vecs[i].addr);
      chk($sformatf("v%0d_data", i), r0[31:0], vecs[i].e_data);
      chk($sformatf("v%0d_lat", i), lat, vecs[i].e_lat);
      chk($sformatf("v%0d_strb", i), strb_cyc, vecs[i].e_strb);
      chk($sformatf("v%0d_ren", i), ren_or, vecs[i].e_ren);
      chk($sformatf("v%0d_wen", i), wen_or, vecs[i].e_wen);
      if (vecs[i].e_strb != 0) chk($sformatf("v%0d_addr_hold", i), addr0, vecs[i].addr);
    end

    // Load and shift while waiting: frame untouched, next status OVERRUN, then OK again.
    hold_ready = 1'b1; rdy_delay = 0;
    shift_in({2'b01, 1'b0, 11'h015, 32'h0});
    pulse_load();
    repeat (3) @(negedge clk);
    s_before = sdo0;
    scan_load = 1'b1; scan_shift = 1'b1; scan_data_in = 1'b1;
    @(negedge clk);
    scan_load = 1'b0; scan_shift = 1'b0; scan_data_in = 1'b0;
    @(negedge clk);
    chk("ovr_frame_hold", sdo0, s_before);
    chk("ovr_busy", busy0, 1);
    chk("ovr_strobe", ren0, 2'b01);
    hold_ready = 1'b0;
    wait_idle(lat);
    shift_out(r0, r1);
    chk("ovr_status", r0[45:44], 2'b11);
    chk("ovr_data", r0[31:0], 32'hDEADBEEF);
    run_cmd(2'b00, 1'b0, 11'h001, 32'hCAFEF00D, 0, r0, lat);
    chk("ovr_cleared", r0[45:44], 2'b00);

    // Ready held low on a WRITE.
    hold_ready = 1'b1;
    shift_in({2'b10, 1'b1, 11'h020, 32'h55AA55AA});
    pulse_load();
`ifdef SCAN_BUS_TIMEOUT_EN
    wait_idle(lat);
    shift_out(r0, r1);
    chk("to_lat", lat, TO + 2);
    chk("to_strb", strb_cyc, TO);
    chk("to_status", r0[45:44], 2'b01);
    chk("to_data", r0[31:0], 0);
`else
    repeat (300) @(negedge clk);
    chk("to_busy_stuck", busy0, 1);
    chk("to_strobe_stuck", wen0, 2'b10);
`endif

    // Reset in WAIT.
    if (!busy0) begin
      shift_in({2'b10, 1'b0, 11'h030, 32'h77777777});
      pulse_load();
      repeat (5) @(negedge clk);
    end
    chk("rstw_in_wait", |(ren0 | wen0), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rstw_ren", ren0, 0); chk("rstw_wen", wen0, 0);
    chk("rstw_busy", busy0, 0); chk("rstw_sdo", sdo0, 0);
    hold_ready = 1'b0;
    run_cmd(2'b01, 1'b1, 11'h015, 32'h0, 1, r0, lat);
    chk("rstw_read_status", r0[45:44], 2'b00);
    chk("rstw_read_data", r0[31:0], 32'h12345678);
    chk("rstw_read_lat", lat, 4);

    // Random commands against the memory model, with ready noise on idle channels.
    noise = 1'b1;
    for (int n = 0; n < 40; n++) begin
      logic [1:0] op; logic ch; logic [AW-1:0] a; logic [DW-1:0] wd, e_data;
      int dly, key; bit go;
      op  = 2'($urandom_range(0, 3));
      ch  = 1'($urandom_range(0, 1));
      a   = 11'(32'h100 + $urandom_range(0, 7));
      wd  = $urandom;
      dly = $urandom_range(0, 3);
      go  = (op == 2'b01) || (op == 2'b10);
      key = int'(ch)*4096 + int'(a);
      e_data = (op == 2'b01) ? (model_mem.exists(key) ? model_mem[key] : '0) : wd;
      if (op == 2'b10) model_mem[key] = wd;
      run_cmd(op, ch, a, wd, dly, r0, lat);
      chk($sformatf("r%0d_status", n), r0[45:44], 2'b00);
      chk($sformatf("r%0d_addr", n), r0[42:32], a);
      chk($sformatf("r%0d_data", n), r0[31:0], e_data);
      chk($sformatf("r%0d_lat", n), lat, go ? 3 + dly : 1);
      chk($sformatf("r%0d_strb", n), strb_cyc, go ? dly + 1 : 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/scan_bus_master.md
# scan_bus_master

Serial scan-driven bus master that turns scanned-in command frames into read/write transactions on N parametrised memory/register channels. It is the single-clock, multi-channel successor of the two-group scan access path used for SRAM and control-register bring-up. Each command is shifted in serially and launched with a load pulse. The result frame (status plus read data) is then shifted back out on the same chain. It sits between the scan pads and the per-group spram / ctr_reg instances.

## Interface
- N_CH, 2, number of target channels (≥1)
- ADDR_W, 11, address width shared by all channels
- DATA_W, 32, data width shared by all channels
- TO_CYC, 255, ready-timeout in cycles (used only with timeout feature)
- Derived: CH_W = max(1, $clog2(N_CH)); FRAME_W = 2 + CH_W + ADDR_W + DATA_W
- clk  in  1  single clock; all logic rising-edge
- rst  in  1  synchronous, active-high reset
- scan_shift  in  1  shift enable: frame register shifts one bit toward MSB per cycle
- scan_data_in  in  1  serial in, enters at LSB
- scan_data_out  out  1  frame register MSB
- scan_load  in  1  single-cycle pulse: latch frame as command and start
- scan_busy  out  1  high from the cycle after an accepted load until the response is loaded
- mem_ren  out  N_CH  one-hot read strobe
- mem_wen  out  N_CH  one-hot write strobe
- mem_addr  out  ADDR_W  shared address
- mem_wdata  out  DATA_W  shared write data
- mem_rdata  in  N_CH*DATA_W  channel c occupies bits [c*DATA_W +: DATA_W]
- mem_ready  in  N_CH  per-channel completion

## Operation
- Command frame, MSB first: op[1:0], ch[CH_W-1:0], addr, wdata. op: 00 NOP, 01 READ, 10 WRITE, 11 treated as NOP.
- Response frame, same width and layout: status[1:0], ch, addr, data. For READ, data = captured rdata. For WRITE and NOP, data = wdata echo. On timeout, data = 0.
- status encodings:
  - 00 OK
  - 01 TIMEOUT
  - 10 BAD_CH (ch ≥ N_CH)
  - 11 OVERRUN (a scan_load arrived while busy; reported in the next response unless TIMEOUT or BAD_CH takes priority)
- FSM states: IDLE, ISSUE, WAIT, RESP.
  - IDLE + scan_load → if NOP or BAD_CH, go to RESP; else go to ISSUE.
  - ISSUE: drive addr/wdata; assert strobe for ch; go to WAIT.
  - WAIT: hold strobe until mem_ready[ch] is sampled high, then go to RESP. The strobe is deasserted on that same edge.
  - RESP: load the response into the frame register, clear the overrun flag, go to IDLE.
- Frame register input priority: rst > RESP load > scan_shift (only when !scan_busy). scan_shift during busy is ignored, so the response is not corrupted.
- scan_load in the same cycle as scan_shift: the load wins and the shift is dropped.
- scan_load while busy: ignored and sets the sticky overrun flag.
- mem_addr and mem_wdata hold their last values after the transaction.
- Reset mid-operation: strobes go low on the next edge. All registers clear, including the overrun flag.

## Timing
- Reset values: scan_data_out 0, scan_busy 0, mem_ren 0, mem_wen 0, mem_addr 0, mem_wdata 0, FSM IDLE, frame register 0.
- scan_load sampled at edge 0 → ISSUE at edge 1 → strobe visible after edge 1.
- If ready is high in the first WAIT cycle: RESP at edge 3, response in the frame register after edge 3, scan_busy low after edge 3.
- Minimum READ/WRITE latency: 3 cycles from load to response. NOP and BAD_CH: 1 cycle, with no strobe.
- mem_ready on a non-selected channel is ignored. Ready asserted before the strobe has no effect.
- Shift-out: FRAME_W shift cycles; the first bit is valid immediately after RESP.

## Configuration
- SCAN_BUS_TIMEOUT_EN defined: an 8..32-bit counter runs in WAIT.
  - When it reaches TO_CYC with no ready, the strobe drops, status becomes TIMEOUT, and data = 0.
  - TO_CYC = 255 means the timeout fires on the 255th WAIT cycle.
- Undefined: WAIT waits indefinitely; TIMEOUT is never reported; TO_CYC is unused.

## Structure
- Package scan_bus_pkg holds:
  - op_e and status_e enums
  - the FSM state enum
  - field-offset functions of (N_CH, ADDR_W, DATA_W)
- Sub-module scan_frame_reg: FRAME_W-bit shift register with parallel load and MSB output, instantiated once.

## Test plan
All scenarios use N_CH=2, ADDR_W=11, DATA_W=32 (FRAME_W=46).
- WRITE ch0, addr 0x015, data 0xDEADBEEF → mem_wen=01 for one handshake; spram word 0x015 = 0xDEADBEEF; response status 00 with data echo.
- READ ch1, addr 0x015 after writing 0x12345678 there → mem_ren=10; response shifts out status 00 and data 0x12345678.
- ch field = 1 with N_CH=1 build → BAD_CH after 1 cycle; no strobe toggles.
- Hold mem_ready low with the macro defined and TO_CYC=16 → strobe drops after 16 WAIT cycles; status 01; data 0. Without the macro, busy stays high.
- Second scan_load and scan_shift pulses during WAIT → frame unchanged; next response status 11; a following command returns 00.
- rst pulse in WAIT → strobes 0 and busy 0 next cycle; a subsequent READ succeeds.
